// File: rtl/matrix_relu_stream.sv
// Captures a ROWS x COLS IEEE-754 matrix in one cycle and streams it out
// row-major through a valid/ready port, zeroing negative non-NaN elements.
module matrix_relu_stream #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic [ROWS-1:0][COLS-1:0][31:0]  in_matrix,
  output logic                             in_ready,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [31:0]                      out_data,
  output logic [RW-1:0]                    out_row,
  output logic [CW-1:0]                    out_col,
  output logic                             out_last,
  output logic                             done
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                          state, state_nxt;
  logic [ROWS-1:0][COLS-1:0][31:0] mat;
  logic [RW-1:0]                   row;
  logic [CW-1:0]                   col;
  logic                            done_r;
  logic                            row_end, col_end, at_last, fire;
  logic [31:0]                     elem;
  logic                            is_nan;

  assign row_end = (row == RW'(ROWS - 1));
  assign col_end = (col == CW'(COLS - 1));
  assign at_last = row_end && col_end;
  assign fire    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = STREAM;
      end
      STREAM: begin
        out_valid = 1'b1;
        if (out_ready && at_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Storage is deliberately left out of reset; only IDLE may overwrite it.
  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && in_valid) mat <= in_matrix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row    <= '0;
      col    <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (fire) begin
        if (col_end) begin
          col <= '0;
          if (row_end) begin
            row    <= '0;
            done_r <= 1'b1;
          end else begin
            row <= row + RW'(1);
          end
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  // Bitwise ReLU: NaNs keep their payload and sign, other negatives become +0.
  assign elem   = mat[row][col];
  assign is_nan = (&elem[30:23]) && (|elem[22:0]);

  assign out_data = (!out_valid)           ? 32'h0 :
                    (elem[31] && !is_nan)  ? 32'h0 : elem;
  assign out_row  = row;
  assign out_col  = col;
  assign out_last = out_valid && at_last;
  assign done     = done_r;

endmodule

// File: tb/tb_matrix_relu_stream.sv
// Scoreboard bench for matrix_relu_stream: directed matrices, stalls, mid-stream
// reset, back-to-back capture and a 1x1 instance.
module tb_matrix_relu_stream;

  typedef logic [3:0][3:0][31:0] mat_t;
  typedef struct {
    logic [31:0] d;
    int          r;
    int          c;
    logic        l;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_last, done;
  mat_t        in_matrix;
  logic [31:0] out_data;
  logic [1:0]  out_row, out_col;

  logic                in_valid1, in_ready1, out_valid1, out_last1, done1;
  logic                out_ready1;
  logic [0:0][0:0][31:0] in_matrix1;
  logic [31:0]         out_data1;
  logic [0:0]          out_row1, out_col1;

  int   checks = 0;
  int   errors = 0;
  int   hs_cnt = 0;
  int   done_cnt = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  matrix_relu_stream #(.ROWS(4), .COLS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_matrix(in_matrix),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_last(out_last), .done(done)
  );

  matrix_relu_stream #(.ROWS(1), .COLS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_matrix(in_matrix1),
    .in_ready(in_ready1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .out_row(out_row1), .out_col(out_col1),
    .out_last(out_last1), .done(done1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input mat_t e);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        exp_t x;
        x.d = e[r][c];
        x.r = r;
        x.c = c;
        x.l = (r == 3 && c == 3);
        sb.push_back(x);
      end
  endtask

  // Single matrix with out_ready held high: checks latency and done timing.
  task automatic run_one(input string nm, input mat_t m, input mat_t e);
    push_exp(e);
    out_ready = 1'b1;
    in_matrix = m;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    chk({nm, "_first_valid"}, {31'b0, out_valid}, 1);
    chk({nm, "_first_rowcol"}, {28'b0, out_row, out_col}, 0);
    chk({nm, "_in_ready_busy"}, {31'b0, in_ready}, 0);
    repeat (16) tick();
    chk({nm, "_done"}, {31'b0, done}, 1);
    chk({nm, "_done_valid"}, {31'b0, out_valid}, 0);
    chk({nm, "_done_ready"}, {31'b0, in_ready}, 1);
    tick();
    chk({nm, "_done_pulse"}, {31'b0, done}, 0);
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  logic        held_v = 1'b0;
  logic [31:0] held_d;
  logic [1:0]  held_r, held_c;
  logic        held_l;
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        chk("stall_valid", {31'b0, out_valid}, 1);
        chk("stall_data", out_data, held_d);
        chk("stall_rowcol", {28'b0, out_row, out_col}, {28'b0, held_r, held_c});
        chk("stall_last", {31'b0, out_last}, {31'b0, held_l});
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h at [%0d][%0d] expected none",
                   out_data, out_row, out_col);
        end else begin
          exp_t x;
          x = sb.pop_front();
          chk("data", out_data, x.d);
          chk("row", {30'b0, out_row}, x.r);
          chk("col", {30'b0, out_col}, x.c);
          chk("last", {31'b0, out_last}, {31'b0, x.l});
        end
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
      held_r = out_row;
      held_c = out_col;
      held_l = out_last;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    mat_t m, e;
    int   hs0, dn0;
    logic got;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_matrix = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b1; in_matrix1 = '0;
    tick(); tick();
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_rowcol", {28'b0, out_row, out_col}, 0);
    chk("rst_last_done", {30'b0, out_last, done}, 0);
    rst = 1'b0;

    // Identity matrix
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[r][c] = (r == c) ? 32'h3F800000 : 32'h0;
    run_one("ident", m, m);

    // ReLU corner values
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        m[r][c] = 32'h40400000;
        e[r][c] = 32'h40400000;
      end
    m[0][0] = 32'hC0200000; e[0][0] = 32'h00000000;
    m[0][1] = 32'h80000000; e[0][1] = 32'h00000000;
    m[1][2] = 32'hFF800000; e[1][2] = 32'h00000000;
    m[2][3] = 32'hFFC00000; e[2][3] = 32'hFFC00000;
    m[3][0] = 32'h7F800000; e[3][0] = 32'h7F800000;
    m[3][3] = 32'hFF800001; e[3][3] = 32'hFF800001;
    m[1][1] = 32'h00000000; e[1][1] = 32'h00000000;
    m[2][0] = 32'h80000001; e[2][0] = 32'h00000000;
    run_one("relu", m, e);

    // Random stalls with in_valid noise during STREAM
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[r][c] = 32'h40000000 + 32'(r * 16 + c);
    push_exp(m);
    in_matrix = m; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    hs0 = hs_cnt; got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      in_matrix = {16{32'h41000000 + 32'(i)}};
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      tick();
      if (!out_valid) begin
        in_valid = 1'b0;
        got = 1'b1;
      end
    end
    chk("stall_finished", {31'b0, got}, 1);
    chk("stall_done", {31'b0, done}, 1);
    chk("stall_handshakes", hs_cnt - hs0, 16);
    out_ready = 1'b1;
    tick();

    // Reset after five accepted elements
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[r][c] = 32'h3F000000 + 32'(r * 4 + c);
    push_exp(m);
    dn0 = done_cnt;
    in_matrix = m; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    hs0 = hs_cnt;
    repeat (5) tick();
    chk("mid_accepted", hs_cnt - hs0, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    chk("mid_rst_valid", {31'b0, out_valid}, 0);
    chk("mid_rst_ready", {31'b0, in_ready}, 1);
    chk("mid_rst_rowcol", {28'b0, out_row, out_col}, 0);
    tick();
    chk("mid_rst_no_done", done_cnt - dn0, 0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[r][c] = 32'h42000000 + 32'(r * 4 + c);
    run_one("restart", m, m);

    // Back-to-back: in_valid held through the done cycle
    dn0 = done_cnt;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        m[r][c] = 32'h3E000000 + 32'(r * 4 + c);
        e[r][c] = 32'h3D000000 + 32'(r * 4 + c);
      end
    push_exp(m);
    push_exp(e);
    in_matrix = m; in_valid = 1'b1;
    tick();
    in_matrix = e;
    repeat (16) tick();
    chk("b2b_done1", {31'b0, done}, 1);
    chk("b2b_ready1", {31'b0, in_ready}, 1);
    tick();
    in_valid = 1'b0;
    chk("b2b_second_valid", {31'b0, out_valid}, 1);
    chk("b2b_second_rowcol", {28'b0, out_row, out_col}, 0);
    repeat (16) tick();
    chk("b2b_done2", {31'b0, done}, 1);
    tick();
    chk("b2b_done_count", done_cnt - dn0, 2);

    // 1x1 instance
    in_matrix1[0][0] = 32'hBF800000; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    chk("one_valid", {31'b0, out_valid1}, 1);
    chk("one_last", {31'b0, out_last1}, 1);
    chk("one_data_neg", out_data1, 32'h0);
    chk("one_rowcol", {30'b0, out_row1, out_col1}, 0);
    tick();
    chk("one_done", {31'b0, done1}, 1);
    chk("one_idle", {30'b0, out_valid1, in_ready1}, 1);
    in_matrix1[0][0] = 32'h7FC00000; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    chk("one_data_nan", out_data1, 32'h7FC00000);
    chk("one_last2", {31'b0, out_last1}, 1);
    tick();

    chk("sb_empty", sb.size(), 0);
    chk("done_total", done_cnt, 6);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_relu_stream.md
MATRIX_RELU_STREAM -- requirements
Module: matrix_relu_stream

Interface
REQ-001 SHALL have parameter ROWS, default 4, rows of the captured matrix (>=1).
REQ-002 SHALL have parameter COLS, default 4, columns of the captured matrix (>=1).
REQ-003 SHALL have localparams RW = max(1,$clog2(ROWS)) and CW = max(1,$clog2(COLS)).
REQ-004 clk  input  1  single clock; all state changes on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  mmmul result available; driven from mmmul done.
REQ-007 in_matrix  input  [ROWS][COLS][31:0]  IEEE-754 single-precision result matrix from mmmul.
REQ-008 in_ready  output  1  block idle and able to capture in_matrix.
REQ-009 out_valid  output  1  out_data holds a valid element.
REQ-010 out_ready  input  1  downstream accepts the element.
REQ-011 out_data  output  32  ReLU-processed element, IEEE-754 single precision.
REQ-012 out_row  output  RW  row index of out_data.
REQ-013 out_col  output  CW  column index of out_data.
REQ-014 out_last  output  1  out_data is element [ROWS-1][COLS-1].
REQ-015 done  output  1  one-cycle pulse after the final element is accepted.

Function
REQ-016 SHALL implement FSM states IDLE and STREAM only.
REQ-017 IDLE: in_ready=1, out_valid=0; on in_valid=1, SHALL register the whole in_matrix and go to STREAM in the next cycle.
REQ-018 STREAM: in_ready=0; in_valid SHALL be ignored and in_matrix changes SHALL NOT affect the captured copy.
REQ-019 out_valid SHALL rise in the cycle after capture, presenting element [0][0]; capture-to-first-output latency is exactly 1 cycle.
REQ-020 Elements SHALL be emitted in row-major order: col increments, wraps to 0 at COLS-1 and row increments.
REQ-021 An element SHALL advance only on a cycle with out_valid && out_ready; the next element is presented the following cycle with no bubble.
REQ-022 While out_valid=1 and out_ready=0, out_data, out_row, out_col and out_last SHALL hold stable.
REQ-023 out_last SHALL be 1 only when out_row=ROWS-1 and out_col=COLS-1.
REQ-024 On the handshake of the last element, the FSM SHALL return to IDLE; in the next cycle done=1 for exactly one cycle, with out_valid=0 and in_ready=1.
REQ-025 An in_valid in the done cycle SHALL be captured, so back-to-back matrices stream with a 1-cycle gap.
REQ-026 ReLU: an element with sign bit 1 that is not NaN (including -0.0 and -inf) SHALL output 32'h00000000.
REQ-027 ReLU: a NaN (exponent 8'hFF, mantissa nonzero) SHALL pass through bit-exact, whatever its sign.
REQ-028 ReLU: an element with sign bit 0 SHALL pass through bit-exact.
REQ-029 ReLU SHALL be purely bitwise, with no arithmetic and no rounding.
REQ-030 ROWS=1 or COLS=1 SHALL work; with ROWS=COLS=1, out_last=1 on the sole element.

Reset
REQ-031 With rst=1 at a posedge, the next state SHALL be IDLE with in_ready=1, out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, done=0.
REQ-032 rst SHALL override in_valid and a handshake in the same cycle; a matrix mid-stream is discarded, and no done is produced for it.
REQ-033 The captured matrix storage need not be cleared by reset.

Verification
REQ-034 Identity 4x4 (1.0=32'h3F800000 on diagonal), in_valid 1 cycle, out_ready=1 -> 16 outputs over 16 consecutive cycles starting 1 cycle after capture; diagonal=32'h3F800000, others 0; out_last on the 16th; done on the following cycle.
REQ-035 Matrix of -2.5 (32'hC0200000), -0.0 (32'h80000000), 32'hFF800000 (-inf) and 32'hFFC00000 (NaN), rest +3.0 -> first three emit 32'h00000000, NaN emits 32'hFFC00000, +3.0 emits 32'h40400000.
REQ-036 out_ready toggled in a pseudo-random pattern -> all values held stable while stalled, exactly 16 handshakes, correct order, in_valid pulses during STREAM ignored.
REQ-037 rst asserted after 5 accepted elements -> next cycle out_valid=0, in_ready=1, no done; a new matrix then streams from [0][0].
REQ-038 in_valid held high through the done cycle -> second matrix captured in the done cycle, first element 1 cycle later, and 2 done pulses total.
